// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch (IFU) and load/store (LSU) requesters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; by default the LSU always wins a tie.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  output logic          ifu_resp_err,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wmask,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  output logic          lsu_resp_err,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e        state_q, state_d;
  logic          owner_lsu_q, owner_lsu_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          grant_ifu_s, grant_lsu_s;
  logic          hs_s, resp_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_lsu_q, last_lsu_d;

  // Tie goes to whichever requester was not granted last
  always_comb begin
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    if (ifu_req_valid && lsu_req_valid) begin
      grant_ifu_s = last_lsu_q;
      grant_lsu_s = !last_lsu_q;
    end else begin
      grant_ifu_s = ifu_req_valid;
      grant_lsu_s = lsu_req_valid;
    end
  end

  // Remember the winner of every accepted request
  always_comb begin
    last_lsu_d = last_lsu_q;
    if (hs_s) begin
      last_lsu_d = grant_lsu_s;
    end else begin
      last_lsu_d = last_lsu_q;
    end
  end

  // Last-grant register; resets to LSU so the first tie goes to IFU
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_lsu_q <= 1'b1;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  // Fixed priority with the LSU ahead of the IFU
  always_comb begin
    grant_lsu_s = lsu_req_valid;
    grant_ifu_s = ifu_req_valid && !lsu_req_valid;
  end
`endif

  assign hs_s   = (state_q == S_IDLE) && (grant_ifu_s || grant_lsu_s);
  assign resp_s = (state_q == S_RESP);

  // Next-state and request/response latching
  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          owner_lsu_d = grant_lsu_s;
          if (grant_lsu_s) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wen ? lsu_wmask : 4'b0000;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = 4'b0000;
          end
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
        // A response arriving in the timeout cycle still wins
        if (mem_resp_valid) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q >= TIMEOUT_C) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_lsu_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= 4'b0000;
      cnt_q       <= 8'd0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign ifu_req_ready  = (state_q == S_IDLE) && grant_ifu_s;
  assign lsu_req_ready  = (state_q == S_IDLE) && grant_lsu_s;

  assign mem_req_valid  = (state_q == S_ISSUE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;

  // Responses are visible only to the owner and only during RESP
  assign ifu_resp_valid = resp_s && !owner_lsu_q;
  assign ifu_rdata      = (resp_s && !owner_lsu_q) ? rdata_q : '0;
  assign ifu_resp_err   = resp_s && !owner_lsu_q && err_q;
  assign lsu_resp_valid = resp_s && owner_lsu_q;
  assign lsu_rdata      = (resp_s && owner_lsu_q) ? rdata_q : '0;
  assign lsu_resp_err   = resp_s && owner_lsu_q && err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares the single DPI-backed physical-memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) of the multi-cycle NPC core. It accepts at most one transaction at a time through valid/ready handshakes, issues it to the memory port, waits for the memory response, and returns read data or a write acknowledge to the owning requester. A watchdog counter terminates transactions whose response never arrives.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: maximum WAIT cycles before an error response; range 1..255.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: reset; asynchronous, active-low.
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_addr` in AW: fetch request; read-only.
- `ifu_resp_valid` out 1, `ifu_rdata` out DW, `ifu_resp_err` out 1: fetch response.
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_addr` in AW: LSU request.
- `lsu_wen` in 1, `lsu_wdata` in DW, `lsu_wmask` in 4: write enable, data and byte mask (ignored when `lsu_wen`=0).
- `lsu_resp_valid` out 1, `lsu_rdata` out DW, `lsu_resp_err` out 1: LSU response.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory-side request handshake.
- `mem_addr` out AW, `mem_wen` out 1, `mem_wdata` out DW, `mem_wmask` out 4: latched request fields.
- `mem_resp_valid` in 1, `mem_rdata` in DW: memory response; one-cycle pulse.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational from the valids. `ifu_req_ready`/`lsu_req_ready` are 1 only for the granted requester, and only in IDLE.
  - On handshake, latch owner, addr, wen, wdata and wmask, then go to ISSUE. IFU requests latch wen=0, wmask=0.
- ISSUE:
  - `mem_req_valid`=1 with the latched fields held stable.
  - On `mem_req_ready`=1, clear the watchdog counter and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - On `mem_resp_valid`=1, latch `mem_rdata` with err=0 and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT, latch rdata=0 with err=1 and go to RESP.
  - If response and timeout happen in the same cycle, the response wins (err=0).
- RESP:
  - Pulse the owner's resp_valid for exactly one cycle with rdata and err, then go to IDLE.
  - Writes also return resp_valid; rdata is the latched memory data.
- `mem_resp_valid` is ignored outside WAIT.
- Requesters hold their request fields stable while valid && !ready. Requesters always accept a response; there is no response backpressure.
- The non-owner's resp_valid is always 0.

## Timing
- Reset (asynchronous assert, any state):
  - State=IDLE; all valid/ready/err outputs 0; rdata outputs 0; mem_* fields 0; counter 0; last-grant=LSU.
  - An in-flight transaction is dropped with no response.
- Best-case latency:
  - Handshake in cycle N.
  - `mem_req_valid` in N+1; with ready=1 there, WAIT in N+2.
  - If `mem_resp_valid` arrives in N+2, resp_valid is asserted in N+3.
- Earliest next accept is the cycle after RESP, so throughput is one transaction per 4 cycles minimum.
- Timeout response is asserted TIMEOUT+1 cycles after WAIT entry.
- Counter is 8 bits and saturates, so it never wraps.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both requesters are valid in IDLE, grant the one not granted last.
  - The last-grant register updates on every handshake.
  - After reset, the first tie goes to IFU.
- Not defined:
  - Fixed priority, LSU always wins ties.
  - The last-grant register is absent.
  - IFU can starve while LSU stays valid.

## Test plan
- IFU read, addr 0x80000000, mem ready immediately, resp next cycle with 0x00000413 -> `ifu_resp_valid` pulses in cycle N+3 with rdata 0x00000413, err=0.
- LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011, `mem_req_ready` held low 3 cycles -> mem fields stable through all 4 ISSUE cycles; then one `lsu_resp_valid` pulse.
- Both valid on consecutive transactions:
  - With `ARB_ROUND_ROBIN_EN`, grants alternate IFU, LSU, IFU.
  - Without it, LSU takes all grants while it stays valid.
- No memory response, TIMEOUT=4 -> `ifu_resp_err`=1 and rdata 0 asserted 5 cycles after WAIT entry; arbiter returns to IDLE.
- Spurious `mem_resp_valid` in IDLE/ISSUE -> ignored. Response arriving on the same cycle as timeout -> err=0 and data delivered.
- `reset` asserted low during WAIT -> outputs 0 immediately, asynchronously; no resp_valid after release; next request completes normally.
